// File: rtl/str_bus_fifo_bridge.sv
// Valid/ready bridge that buffers words from a slave-side bus to a master-side bus
// through a DEPTH-entry first-word-fall-through FIFO with flush and occupancy stats.
module str_bus_fifo_bridge #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              flush,
   output logic [CNT_W-1:0]  level,
   output logic [CNT_W-1:0]  max_level,
   output logic              almost_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_LVL    = CNT_W'(AF_THRESH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  level_q, level_d;
   logic [CNT_W-1:0]  max_level_q, max_level_d;
   logic              push, pop;

   // Ready depends only on registered level and flush, so no path from in_valid.
   assign in_ready    = (level_q != FULL_LVL) && !flush;
   assign out_valid   = (level_q != '0);
   assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
   assign level       = level_q;
   assign max_level   = max_level_q;
   assign almost_full = (level_q >= AF_LVL);

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      max_level_d = max_level_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         max_level_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         level_d = level_q + CNT_W'(push) - CNT_W'(pop);
         if (level_d > max_level_q) max_level_d = level_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         max_level_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         max_level_q <= max_level_d;
      end
   end

   // Payload storage is deliberately left unreset; validity comes from level_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

endmodule

// File: tb/tb_str_bus_fifo_bridge.sv
// Directed bench for str_bus_fifo_bridge: every cycle is checked against a queue model,
// with hand-computed spot checks at the interesting boundaries.
module tb_str_bus_fifo_bridge;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic       flush;
   logic [2:0] level;
   logic [2:0] max_level;
   logic       almost_full;

   int tb_total = 0;
   int tb_bad   = 0;

   logic [7:0] exp_q[$];
   int         m_max = 0;

   str_bus_fifo_bridge #(.DATA_W(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .flush(flush), .level(level), .max_level(max_level), .almost_full(almost_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      tb_total++;
      assert (obs === expv) else begin
         tb_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Checks every output against the queue model, then advances one clock edge.
   task automatic cycle();
      logic       e_rdy, e_ov, do_push, do_pop;
      logic [7:0] e_od;
      int         sz;
      #1;
      sz    = exp_q.size();
      e_rdy = (sz != 4) && !flush;
      e_ov  = (sz != 0);
      e_od  = e_ov ? exp_q[0] : 8'h00;
      chk("in_ready",    16'(in_ready),    16'(e_rdy));
      chk("out_valid",   16'(out_valid),   16'(e_ov));
      chk("out_data",    16'(out_data),    16'(e_od));
      chk("level",       16'(level),       16'(sz));
      chk("max_level",   16'(max_level),   16'(m_max));
      chk("almost_full", 16'(almost_full), 16'(sz >= 3));
      do_push = in_valid && e_rdy;
      do_pop  = e_ov && out_ready;
      @(posedge clk);
      if (flush) begin
         exp_q.delete();
         m_max = 0;
      end else begin
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(in_data);
         if (exp_q.size() > m_max) m_max = exp_q.size();
      end
      #1;
   endtask

   task automatic push_word(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
      chk("drain_budget", 16'(exp_q.size()), 16'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      out_ready = 1'b0; flush = 1'b0;
      #12;
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_out_data",  16'(out_data),  16'h00);
      chk("rst_level",     16'(level),     16'd0);
      chk("rst_max_level", 16'(max_level), 16'd0);
      chk("rst_af",        16'(almost_full), 16'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 16'(in_ready), 16'd1);

      // Single word, then hold reset and confirm outputs clear.
      push_word(8'hA5);
      chk("single_valid", 16'(out_valid), 16'd1);
      chk("single_data",  16'(out_data),  16'hA5);
      chk("single_level", 16'(level),     16'd1);
      chk("single_max",   16'(max_level), 16'd1);
      rst_n = 1'b0; #1;
      chk("rstlow_valid", 16'(out_valid), 16'd0);
      chk("rstlow_data",  16'(out_data),  16'h00);
      exp_q.delete(); m_max = 0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fill to full; almost_full from level 3.
      push_word(8'h01);
      push_word(8'h02);
      chk("af_at_2", 16'(almost_full), 16'd0);
      push_word(8'h03);
      chk("af_at_3", 16'(almost_full), 16'd1);
      push_word(8'h04);
      chk("full_level", 16'(level), 16'd4);
      chk("full_ready", 16'(in_ready), 16'd0);
      push_word(8'h05);
      chk("full_reject_level", 16'(level), 16'd4);
      out_ready = 1'b1;
      cycle(); chk("drain0_next", 16'(out_data), 16'h02);
      cycle(); chk("drain1_next", 16'(out_data), 16'h03);
      cycle(); chk("drain2_next", 16'(out_data), 16'h04);
      cycle(); chk("drain_empty", 16'(out_valid), 16'd0);
      out_ready = 1'b0;

      // Full with concurrent ready: pop but no push, then accept next cycle.
      for (int i = 1; i <= 4; i++) push_word(8'(i));
      in_valid = 1'b1; in_data = 8'h10; out_ready = 1'b1;
      cycle();
      chk("fullrdy_level", 16'(level),    16'd3);
      chk("fullrdy_head",  16'(out_data), 16'h02);
      out_ready = 1'b0;
      cycle();
      chk("fullrdy_accept", 16'(level), 16'd4);
      in_valid = 1'b0;
      drain(10);

      // Streaming with both sides always ready: level holds at 1.
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 8'(8'h40 + i);
         cycle();
         chk("stream_level", 16'(level),    16'd1);
         chk("stream_data",  16'(out_data), 16'(8'h40 + i));
      end
      in_valid = 1'b0;
      drain(10);

      // Random stalls on both sides.
      for (int i = 0; i < 200; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom_range(0, 255));
         out_ready = 1'($urandom_range(0, 3) != 0 ? (i % 40 < 20) : 1);
         cycle();
      end
      drain(10);

      // Flush mid-stream with push and pop requested.
      push_word(8'h31); push_word(8'h32); push_word(8'h33);
      chk("preflush_level", 16'(level), 16'd3);
      flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
      cycle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("flush_level", 16'(level),     16'd0);
      chk("flush_max",   16'(max_level), 16'd0);
      chk("flush_valid", 16'(out_valid), 16'd0);
      push_word(8'h77);
      chk("postflush_data", 16'(out_data), 16'h77);
      drain(10);

      // Asynchronous reset between edges at level 2.
      push_word(8'h51); push_word(8'h52);
      chk("prereset_level", 16'(level), 16'd2);
      #1 rst_n = 1'b0;
      #1;
      chk("async_valid", 16'(out_valid), 16'd0);
      chk("async_level", 16'(level),     16'd0);
      exp_q.delete(); m_max = 0;
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      push_word(8'h99);
      chk("postreset_data", 16'(out_data), 16'h99);
      drain(10);

      $display("test done: total=%0d bad=%0d", tb_total, tb_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/str_bus_fifo_bridge.md
Name: str_bus_fifo_bridge

Overview:
- Parametrised successor to the single-register bus bridge: moves words from a slave-side valid/ready bus to a master-side valid/ready bus through a DEPTH-entry FIFO.
- Adds full backpressure on both sides, a synchronous flush, an almost-full flag, a level output and a sticky high-water mark.
- Sits between two bus agents inside str-level test structures. Used wherever a pure pipeline register would drop or duplicate data under stall.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- DEPTH, 4, FIFO entries; power of two, >=2.
- AF_THRESH, DEPTH-1, level at or above which almost_full asserts (1..DEPTH).
- CNT_W, $clog2(DEPTH+1), derived width of level outputs; not to be overridden.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  slave-side word available.
- in_data  input  DATA_W  slave-side payload.
- in_ready  output  1  bridge accepts word this cycle.
- out_valid  output  1  master-side word available.
- out_data  output  DATA_W  master-side payload (head of FIFO).
- out_ready  input  1  downstream accepts word this cycle.
- flush  input  1  synchronous clear of FIFO contents and high-water mark.
- level  output  CNT_W  current occupancy, 0..DEPTH.
- max_level  output  CNT_W  sticky maximum of level since reset/flush.
- almost_full  output  1  level >= AF_THRESH.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, level=0, max_level=0. Outputs: out_valid=0, out_data=0, almost_full=0. in_ready=1 once rst_n is high. Storage array is not reset.
- in_ready = (level != DEPTH) && !flush. Combinational from state and flush only; never from in_valid.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- out_valid = (level != 0). out_data = mem[rd_ptr] when out_valid, else all-zero. First-word fall-through.
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 after edge N. No combinational in->out path.
- Per edge:
  - push: write mem[wr_ptr], then wr_ptr+1.
  - pop: rd_ptr+1.
  - level += push - pop.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Simultaneous push and pop at 0 < level < DEPTH: level unchanged; both pointers advance.
- Full (level=DEPTH): in_ready=0 even if out_ready=1 in the same cycle; no full-cycle bypass. in_ready rises the cycle after a pop.
- Empty (level=0): out_valid=0; pop impossible. A push into an empty FIFO yields out_valid=1 next cycle.
- Stability rules:
  - Once out_valid=1, out_data holds stable until popped or flushed.
  - The bridge never deasserts out_valid without a pop or flush.
- flush=1 at an edge:
  - wr_ptr, rd_ptr and level go to 0; max_level goes to 0.
  - No push occurs (in_ready=0). Any pop in that cycle is discarded.
  - Flush has priority over push and pop.
- max_level: at each non-flush edge, max_level <= max(max_level, next level). It never decreases except on flush or reset.
- almost_full: registered-equivalent, i.e. a combinational decode of the level register.
- Reset asserted mid-transfer: all in-flight words are lost; outputs go to their reset values immediately (asynchronously).
- Upstream handshake rule: upstream may hold in_valid with changing in_data while in_ready=0. The bridge samples in_data only on push.

Test Plan:
- Reset then single word: in_data=8'hA5 pushed with out_ready=0. Next cycle out_valid=1, out_data=8'hA5, level=1, max_level=1. While rst_n is held low: out_valid=0, out_data=8'h00.
- Fill to full (DEPTH=4, out_ready=0): push 8'h01..8'h04. Then level=4, in_ready=0, almost_full=1 (AF_THRESH=3, asserted from level=3). A fifth in_valid is not accepted. Drain yields 01,02,03,04 in order, then out_valid=0.
- Full with concurrent ready: at level=4, in_valid=1 and out_ready=1 in the same cycle. 8'h01 pops and no push occurs; level=3. The next cycle accepts the word.
- Streaming wrap: in_valid=out_ready=1 for 20 cycles, incrementing data. Output equals input delayed by 1 cycle, level stays 1, pointers wrap without loss. Random out_ready stalls: scoreboard shows no loss or duplication.
- Flush mid-stream: at level=3, assert flush with in_valid=1 and out_ready=1. Next cycle level=0, max_level=0, out_valid=0, and the pushed word is absent from later output.
- Async reset mid-operation: drop rst_n between clock edges at level=2. out_valid and level read 0 before the next edge. After release, the first pushed word is the first output.
